// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired zero register,
// asynchronous clear, write-to-read bypass and a per-register
// pending-write scoreboard for long-latency producers.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      WE,
  input  logic [NWR*AW-1:0]   WA,
  input  logic [NWR*XLEN-1:0] WD,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]      RBUSY,
  input  logic                SB_SET,
  input  logic [AW-1:0]       SB_A,
  output logic                SB_ANY
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nxt;
  logic [NWR-1:0]   w_wacc;
  logic             w_sb_ok;

  // Address names a real, writable register (in range, not the zero register).
  function automatic logic f_valid(input logic [AW-1:0] a);
    f_valid = (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Qualify write ports and the scoreboard set against the address map.
  always_comb begin
    w_wacc = '0;
    for (int unsigned k = 0; k < NWR; k++) begin
      w_wacc[k] = WE[k] && f_valid(WA[k*AW +: AW]);
    end
    w_sb_ok = SB_SET && f_valid(SB_A);
  end

  // Register storage; later ports overwrite earlier ones so port 1 wins conflicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (w_wacc[k]) begin
          r_regs[WA[k*AW +: AW]] <= WD[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Next pending vector: writes retire a producer, a same-edge set re-arms it.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (w_wacc[k]) begin
        w_pend_nxt[WA[k*AW +: AW]] = 1'b0;
      end
    end
    if (w_sb_ok) begin
      w_pend_nxt[SB_A] = 1'b1;
    end
  end

  // Pending-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Combinational read ports with optional same-cycle forwarding; outputs held
  // at zero during reset so bypassed write data cannot leak out.
  always_comb begin
    RD    = '0;
    RBUSY = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (f_valid(RA[i*AW +: AW])) begin
        RD[i*XLEN +: XLEN] = r_regs[RA[i*AW +: AW]];
        RBUSY[i]           = r_pend[RA[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int unsigned k = 0; k < NWR; k++) begin
            if (w_wacc[k] && (WA[k*AW +: AW] == RA[i*AW +: AW])) begin
              RD[i*XLEN +: XLEN] = WD[k*XLEN +: XLEN];
              if (!(SB_SET && (SB_A == RA[i*AW +: AW]))) begin
                RBUSY[i] = 1'b0;
              end
            end
          end
        end
      end
    end
    if (!rst_n) begin
      RD    = '0;
      RBUSY = '0;
    end
  end

  // Any outstanding producer, from registered state only.
  always_comb begin
    SB_ANY = rst_n && (|r_pend);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: A = 24 regs, 2R/2W, bypass on; B = 32 regs, 1R/1W, bypass off.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  WE;
  logic [9:0]  WA;
  logic [63:0] WD;
  logic [9:0]  RA;
  logic        SB_SET;
  logic [4:0]  SB_A;

  logic [63:0] rd_a;
  logic [1:0]  rbusy_a;
  logic        sbany_a;
  logic [31:0] rd_b;
  logic [0:0]  rbusy_b;
  logic        sbany_b;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .WE(WE), .WA(WA), .WD(WD), .RA(RA),
    .RD(rd_a), .RBUSY(rbusy_a), .SB_SET(SB_SET), .SB_A(SB_A), .SB_ANY(sbany_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .WE(WE[0:0]), .WA(WA[4:0]), .WD(WD[31:0]), .RA(RA[4:0]),
    .RD(rd_b), .RBUSY(rbusy_b), .SB_SET(SB_SET), .SB_A(SB_A), .SB_ANY(sbany_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    WE     = '0;
    SB_SET = 1'b0;
  endtask

  task automatic setw(input int p, input logic [4:0] a, input logic [31:0] d);
    WE[p]         = 1'b1;
    WA[p*5 +: 5]  = a;
    WD[p*32 +: 32] = d;
  endtask

  initial begin
    rst_n = 1'b0; WE = '0; WA = '0; WD = '0; RA = '0; SB_SET = 1'b0; SB_A = '0;
    #3;
    chk("rst_rd_a",    rd_a[31:0],      32'h0);
    chk("rst_rbusy_a", 32'(rbusy_a),    32'h0);
    chk("rst_sbany_a", 32'(sbany_a),    32'h0);
    #4 rst_n = 1'b1;

    // Reset clear: write x5, then pulse reset between edges
    @(negedge clk); setw(0, 5'd5, 32'hDEADBEEF); RA[4:0] = 5'd5;
    #2;
    chk("byp_x5_a", rd_a[31:0], 32'hDEADBEEF);
    chk("nobyp_x5_b", rd_b, 32'h0);
    @(posedge clk); #1; idle();
    chk("wr_x5_a", rd_a[31:0], 32'hDEADBEEF);
    chk("wr_x5_b", rd_b,       32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_clr_a", rd_a[31:0], 32'h0);
    chk("async_clr_b", rd_b,       32'h0);
    setw(0, 5'd5, 32'hCAFE0000); SB_SET = 1'b1; SB_A = 5'd5;
    #1;
    chk("rst_gate_byp_a", rd_a[31:0], 32'h0);
    chk("rst_rbusy_a2",   32'(rbusy_a), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_rd_a",    rd_a[31:0],   32'h0);
    chk("rst_hold_sbany_a", 32'(sbany_a), 32'h0);
    idle(); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_x5_a",    rd_a[31:0],   32'h0);
    chk("post_rst_sbany_a", 32'(sbany_a), 32'h0);

    // Zero register ignores writes and scoreboard sets
    @(negedge clk); setw(0, 5'd0, 32'hFFFFFFFF); SB_SET = 1'b1; SB_A = 5'd0; RA = '0;
    #2;
    chk("x0_byp_a",  rd_a[31:0], 32'h0);
    chk("x0_rd1_a",  rd_a[63:32], 32'h0);
    chk("x0_rd_b",   rd_b, 32'h0);
    @(posedge clk); #1; idle();
    chk("x0_after_a",    rd_a[31:0],   32'h0);
    chk("x0_rbusy_a",    32'(rbusy_a), 32'h0);
    chk("x0_sbany_a",    32'(sbany_a), 32'h0);
    chk("x0_sbany_b",    32'(sbany_b), 32'h0);

    // Bypass vs stored read
    @(negedge clk); setw(0, 5'd7, 32'h11); RA[4:0] = 5'd7;
    @(posedge clk); #1;
    chk("x7_init_a", rd_a[31:0], 32'h11);
    chk("x7_init_b", rd_b,       32'h11);
    @(negedge clk); setw(0, 5'd7, 32'h22);
    #2;
    chk("x7_byp_a",   rd_a[31:0], 32'h22);
    chk("x7_nobyp_b", rd_b,       32'h11);
    @(posedge clk); #1; idle();
    chk("x7_after_a", rd_a[31:0], 32'h22);
    chk("x7_after_b", rd_b,       32'h22);

    // Two ports to the same address: port 1 wins
    @(negedge clk); setw(0, 5'd3, 32'hAAAA); setw(1, 5'd3, 32'h5555); RA[9:5] = 5'd3;
    #2;
    chk("conf_byp_a", rd_a[63:32], 32'h5555);
    @(posedge clk); #1; idle();
    chk("conf_x3_a", rd_a[63:32], 32'h5555);
    RA[4:0] = 5'd3; #1;
    chk("conf_x3_p0_a", rd_a[31:0], 32'h5555);
    chk("x3_b",         rd_b,       32'hAAAA);

    // Scoreboard set, hold, clear by write, set-wins on the same edge
    @(negedge clk); SB_SET = 1'b1; SB_A = 5'd9; RA[4:0] = 5'd9;
    #2;
    chk("sb_pre_rbusy_a", 32'(rbusy_a[0]), 32'h0);
    chk("sb_pre_sbany_a", 32'(sbany_a),    32'h0);
    @(posedge clk); #1; idle();
    chk("sb_set_rbusy_a", 32'(rbusy_a[0]), 32'h1);
    chk("sb_set_sbany_a", 32'(sbany_a),    32'h1);
    chk("sb_set_rbusy_b", 32'(rbusy_b),    32'h1);
    @(negedge clk); @(negedge clk);
    chk("sb_hold_rbusy_a", 32'(rbusy_a[0]), 32'h1);
    @(negedge clk); setw(0, 5'd9, 32'h99);
    #2;
    chk("sb_wbyp_rbusy_a", 32'(rbusy_a[0]), 32'h0);
    chk("sb_wbyp_rbusy_b", 32'(rbusy_b),    32'h1);
    chk("sb_wbyp_sbany_a", 32'(sbany_a),    32'h1);
    @(posedge clk); #1; idle();
    chk("sb_clr_rbusy_a", 32'(rbusy_a[0]), 32'h0);
    chk("sb_clr_sbany_a", 32'(sbany_a),    32'h0);
    chk("sb_clr_sbany_b", 32'(sbany_b),    32'h0);
    chk("sb_clr_rd_a",    rd_a[31:0],      32'h99);
    @(negedge clk); setw(0, 5'd9, 32'h100); SB_SET = 1'b1; SB_A = 5'd9;
    #2;
    chk("sb_both_byp_rd_a", rd_a[31:0], 32'h100);
    @(posedge clk); #1; idle();
    chk("sb_both_rbusy_a", 32'(rbusy_a[0]), 32'h1);
    chk("sb_both_sbany_a", 32'(sbany_a),    32'h1);
    chk("sb_both_sbany_b", 32'(sbany_b),    32'h1);
    @(negedge clk); setw(1, 5'd9, 32'h200);
    #2;
    chk("sb_p1_rbusy_a", 32'(rbusy_a[0]), 32'h0);
    chk("sb_p1_rd_a",    rd_a[31:0],      32'h200);
    @(posedge clk); #1; idle();
    chk("sb_p1_sbany_a", 32'(sbany_a), 32'h0);
    chk("sb_p1_sbany_b", 32'(sbany_b), 32'h1);
    @(negedge clk); setw(0, 5'd9, 32'h300);
    @(posedge clk); #1; idle();
    chk("sb_b_clr_sbany_b", 32'(sbany_b), 32'h0);

    // Out-of-range address on the 24-entry file
    @(negedge clk);
    setw(0, 5'd30, 32'h1234); setw(1, 5'd23, 32'h2323);
    SB_SET = 1'b1; SB_A = 5'd30; RA[4:0] = 5'd30; RA[9:5] = 5'd23;
    #2;
    chk("oor_byp_rd_a",  rd_a[31:0],  32'h0);
    chk("last_byp_rd_a", rd_a[63:32], 32'h2323);
    chk("oor_pre_rd_b",  rd_b,        32'h0);
    @(posedge clk); #1; idle();
    chk("oor_rd_a",      rd_a[31:0],   32'h0);
    chk("last_rd_a",     rd_a[63:32],  32'h2323);
    chk("oor_rbusy_a",   32'(rbusy_a), 32'h0);
    chk("oor_sbany_a",   32'(sbany_a), 32'h0);
    chk("x30_rd_b",      rd_b,         32'h1234);
    chk("x30_rbusy_b",   32'(rbusy_b), 32'h1);
    chk("x30_sbany_b",   32'(sbany_b), 32'h1);
    RA[4:0] = 5'd6; RA[9:5] = 5'd14; #1;
    chk("x6_intact_a",  rd_a[31:0],  32'h0);
    chk("x14_intact_a", rd_a[63:32], 32'h0);
    RA[4:0] = 5'd3; RA[9:5] = 5'd7; #1;
    chk("x3_intact_a", rd_a[31:0],  32'h5555);
    chk("x7_intact_a", rd_a[63:32], 32'h22);
    RA[4:0] = 5'd9; #1;
    chk("x9_final_a", rd_a[31:0], 32'h300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
